read_iq: RTL and testbench
==========================

# read_iq

Front-end stage of the FM radio pipeline. It consumes the raw interleaved I/Q byte stream from the input byte FIFO and assembles each group of 4 bytes into one I sample and one Q sample. Each sample is a little-endian 16-bit signed value, sign-extended and quantized (left-shifted by BITS) to 32 bits. The resulting I and Q words are written in lockstep into the I and Q FIFOs that feed the complex channel FIR.

## Interface
- DATA_WIDTH, 32 — output sample width.
- BITS, 10 — quantization shift; legal range 0..(DATA_WIDTH-16).
- clock  input  1  — single clock; all state on rising edge.
- reset  input  1  — asynchronous, active-low.
- in_dout  input  8  — head byte of input FIFO; valid while in_empty low (show-ahead FIFO).
- in_empty  input  1  — input FIFO empty.
- in_rd_en  output  1  — pop head byte at this clock edge.
- i_out  output  DATA_WIDTH  — quantized I sample.
- i_wr_en  output  1  — write i_out into I FIFO this edge.
- i_full  input  1  — I FIFO full.
- q_out  output  DATA_WIDTH  — quantized Q sample.
- q_wr_en  output  1  — write q_out into Q FIFO this edge.
- q_full  input  1  — Q FIFO full.
- sample_count  output  32  — number of I/Q pairs written since reset.

## Operation
- Byte order per sample: I_lo, I_hi, Q_lo, Q_hi.
- FSM states: S_I0, S_I1, S_Q0, S_Q1, S_WRITE. Reset state is S_I0.
- Byte states:
  - in_rd_en = !in_empty (combinational, only in S_I0..S_Q1).
  - On a pop, the byte is captured into its holding register and the FSM advances one state.
  - While empty, the FSM holds.
  - S_Q1 advances to S_WRITE.
- S_WRITE:
  - i_wr_en = q_wr_en = !i_full && !q_full (combinational, same value on both).
  - On the write edge: FSM → S_I0 and sample_count increments.
  - Otherwise FSM holds, and no bytes are popped.
- I and Q are always written on the same edge; a full on either FIFO stalls both.
- Arithmetic:
  - s16 = {hi, lo} interpreted as signed.
  - out = sign-extend(s16) to DATA_WIDTH, then << BITS; the low BITS bits are zero.
  - No rounding or saturation; the result always fits because 16+BITS ≤ DATA_WIDTH.
- i_out/q_out are registers loaded on the S_Q1 pop edge from the holding registers plus the incoming Q_hi byte. They are stable throughout S_WRITE and hold their value until the next sample's load.
- sample_count wraps from 0xFFFFFFFF to 0.
- Reset (asserted at any time, including mid-sample):
  - state ← S_I0; holding registers, i_out, q_out and sample_count ← 0.
  - Partial bytes are discarded.
  - in_rd_en, i_wr_en and q_wr_en are 0 while reset is low.

## Timing
- Minimum of 5 cycles per sample: 4 pop cycles plus 1 write cycle. Peak rate is 0.8 bytes/cycle.
- Latency is 1 cycle: the cycle after the Q_hi pop edge, i_wr_en/q_wr_en assert if neither FIFO is full.
- in_rd_en is never asserted while in_empty = 1 or in S_WRITE.
- i_wr_en/q_wr_en are never asserted while either full is high.
- A full flag that drops and rises again before the write produces no write; there is no lost or duplicated sample.
- Full/empty inputs are sampled combinationally in the same cycle; no extra pipeline stage.

## Test plan
- Basic sample: bytes 0x34,0x12,0x78,0x56 → one write with i_out=0x0048D000, q_out=0x0159E000; sample_count=1; write 1 cycle after 4th pop.
- Sign handling: bytes 0x00,0x80,0xFF,0xFF → i_out=0xFE000000, q_out=0xFFFFFC00.
- Backpressure: after 4 bytes, hold q_full=1 for 10 cycles with more bytes queued → no wr_en and in_rd_en=0 throughout. Release → exactly one write, then popping resumes next cycle.
- Starved input: in_empty asserted for 3 cycles between every byte → in_rd_en only when not empty; outputs identical to basic-sample values.
- Reset mid-sample: pop 2 bytes, pulse reset low → all outputs 0, state S_I0. Then feed 0x01,0x00,0x02,0x00 → i_out=0x00000400, q_out=0x00000800.
- Streaming: 256 bytes back-to-back, FIFOs never full → 64 writes, one every 5 cycles; sample_count=64; values match a 16-bit-to-BITS reference model.

Source files
------------

// File: rtl/read_iq.sv
// Packs the interleaved I_lo,I_hi,Q_lo,Q_hi byte stream into sign-extended, BITS-quantized I/Q words.
// 4 pop cycles + 1 write cycle per sample; a full on either output FIFO stalls both writes and byte intake.
module read_iq #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic                  i_wr_en,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  q_wr_en,
  input  logic                  q_full,
  output logic [31:0]           sample_count
);

  typedef enum logic [2:0] {
    S_I0,
    S_I1,
    S_Q0,
    S_Q1,
    S_WRITE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       pop;
  logic       push;
  logic [7:0] i_lo;
  logic [7:0] i_hi;
  logic [7:0] q_lo;

  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [7:0] hi, input logic [7:0] lo);
    logic signed [15:0]           s16;
    logic signed [DATA_WIDTH-1:0] ext;
    s16 = {hi, lo};
    ext = s16;
    return ext <<< BITS;
  endfunction

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      S_I0: begin
        pop = !in_empty;
        if (pop) state_nxt = S_I1;
      end
      S_I1: begin
        pop = !in_empty;
        if (pop) state_nxt = S_Q0;
      end
      S_Q0: begin
        pop = !in_empty;
        if (pop) state_nxt = S_Q1;
      end
      S_Q1: begin
        pop = !in_empty;
        if (pop) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        push = !i_full && !q_full;
        if (push) state_nxt = S_I0;
      end
      default: state_nxt = S_I0;
    endcase
  end

  // Strobes are qualified with reset so nothing moves while it is held low.
  assign in_rd_en = pop && reset;
  assign i_wr_en  = push && reset;
  assign q_wr_en  = push && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_I0;
      i_lo         <= '0;
      i_hi         <= '0;
      q_lo         <= '0;
      i_out        <= '0;
      q_out        <= '0;
      sample_count <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        case (state)
          S_I0: i_lo <= in_dout;
          S_I1: i_hi <= in_dout;
          S_Q0: q_lo <= in_dout;
          S_Q1: begin
            // Q_hi goes straight from the FIFO head; no holding register needed.
            i_out <= quantize(i_hi, i_lo);
            q_out <= quantize(in_dout, q_lo);
          end
          default: ;
        endcase
      end
      if (push) sample_count <= sample_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Randomized bench for read_iq: a show-ahead byte source, controllable full flags and a byte-group reference model.
module tb_read_iq;
  localparam int DW   = 32;
  localparam int BITS = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_dout = 8'h00;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] i_out;
  logic          i_wr_en;
  logic          i_full = 1'b0;
  logic [DW-1:0] q_out;
  logic          q_wr_en;
  logic          q_full = 1'b0;
  logic [31:0]   sample_count;

  read_iq #(.DATA_WIDTH(DW), .BITS(BITS)) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .i_out(i_out), .i_wr_en(i_wr_en), .i_full(i_full), .q_out(q_out), .q_wr_en(q_wr_en),
    .q_full(q_full), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  byte unsigned src[$];
  byte unsigned fed[$];
  logic [31:0]  wr_i[$];
  logic [31:0]  wr_q[$];
  int           wr_cyc[$];
  int           cyc = 0;
  int           last_pop_cyc = 0;
  int           nb = 0;
  int           viol = 0;
  int           terr = 0;
  int           gap = 0;
  int           starve = 0;
  int           n_since_reset = 0;
  bit           rand_full = 0;
  bit           rand_empty = 0;
  bit           want_i_full = 0;
  bit           want_q_full = 0;

  function automatic logic [31:0] ref_q(input byte unsigned lo, input byte unsigned hi);
    logic signed [15:0] s;
    longint             v;
    s = {hi, lo};
    v = longint'(s) * (longint'(1) << BITS);
    return v[31:0];
  endfunction

  task automatic feed(input byte unsigned b);
    src.push_back(b);
    fed.push_back(b);
  endtask

  task automatic begin_test();
    fed.delete();
    wr_i.delete();
    wr_q.delete();
    wr_cyc.delete();
    viol = 0;
    terr = 0;
  endtask

  // One clock: drive at negedge, observe #1 later, advance the model for the coming posedge.
  task automatic step();
    bit e;
    bit exp_rd;
    bit exp_wr;
    @(negedge clock);
    if (rand_empty) e = ($urandom_range(0, 2) == 0);
    else e = (starve > 0);
    e = e || (src.size() == 0);
    if (starve > 0) starve--;
    in_empty = e;
    in_dout  = e ? 8'($urandom) : src[0];
    if (rand_full) begin
      i_full = ($urandom_range(0, 3) == 0);
      q_full = ($urandom_range(0, 3) == 0);
    end else begin
      i_full = want_i_full;
      q_full = want_q_full;
    end
    #1;
    // At most one assembled sample may wait; bytes are only taken while none is waiting.
    exp_rd = !e && (nb < 4);
    exp_wr = (nb == 4) && !i_full && !q_full;
    if (in_rd_en !== exp_rd || i_wr_en !== exp_wr) terr++;
    if (in_rd_en === 1'b1 && e) viol++;
    if (i_wr_en !== q_wr_en) viol++;
    if (i_wr_en === 1'b1 && (i_full || q_full)) viol++;
    if (i_wr_en === 1'b1 && in_rd_en === 1'b1) viol++;
    if (in_rd_en === 1'b1 && !e) begin
      void'(src.pop_front());
      nb++;
      last_pop_cyc = cyc;
      starve = gap;
    end
    if (i_wr_en === 1'b1) begin
      wr_i.push_back(i_out);
      wr_q.push_back(q_out);
      wr_cyc.push_back(cyc);
      nb = 0;
      n_since_reset++;
    end
    cyc++;
  endtask

  task automatic run_writes(input int n, input int budget, output bit timed_out);
    int start;
    int k;
    start = wr_i.size();
    k = 0;
    while ((wr_i.size() - start) < n && k < budget) begin
      step();
      k++;
    end
    timed_out = ((wr_i.size() - start) < n);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset    = 1'b0;
    in_empty = (src.size() == 0);
    in_dout  = (src.size() != 0) ? src[0] : 8'h00;
    i_full   = 1'b0;
    q_full   = 1'b0;
    nb = 0;
    n_since_reset = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    in_empty = 1'b1;
    reset    = 1'b1;
  endtask

  task automatic test_reset();
    feed(8'h11); feed(8'h22);
    apply_reset();
    tests++; if (in_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", in_rd_en); end
    tests++; if (i_wr_en !== 1'b0) begin fails++; $display("FAIL reset_i_wr_en: got %b want 0", i_wr_en); end
    tests++; if (q_wr_en !== 1'b0) begin fails++; $display("FAIL reset_q_wr_en: got %b want 0", q_wr_en); end
    tests++; if (i_out !== 32'h0) begin fails++; $display("FAIL reset_i_out: got %h want 0", i_out); end
    tests++; if (q_out !== 32'h0) begin fails++; $display("FAIL reset_q_out: got %h want 0", q_out); end
    tests++; if (sample_count !== 32'h0) begin fails++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    src.delete();
    release_reset();
  endtask

  task automatic test_basic();
    bit to;
    begin_test();
    feed(8'h34); feed(8'h12); feed(8'h78); feed(8'h56);
    run_writes(1, 40, to);
    step();
    tests++; if (to) begin fails++; $display("FAIL basic_timeout: got %0d writes want 1", wr_i.size()); end
    if (wr_i.size() > 0) begin
      tests++; if (wr_i[0] !== 32'h0048D000) begin fails++; $display("FAIL basic_i: got %h want 0048d000", wr_i[0]); end
      tests++; if (wr_q[0] !== 32'h0159E000) begin fails++; $display("FAIL basic_q: got %h want 0159e000", wr_q[0]); end
      tests++; if (wr_cyc[0] - last_pop_cyc !== 1) begin fails++; $display("FAIL basic_latency: got %0d want 1", wr_cyc[0] - last_pop_cyc); end
    end
    tests++; if (i_out !== 32'h0048D000) begin fails++; $display("FAIL basic_hold: got %h want 0048d000", i_out); end
    tests++; if (sample_count !== 32'd1) begin fails++; $display("FAIL basic_count: got %0d want 1", sample_count); end
    tests++; if (terr !== 0 || viol !== 0) begin fails++; $display("FAIL basic_protocol: got %0d/%0d want 0/0", terr, viol); end
  endtask

  task automatic test_sign();
    bit to;
    begin_test();
    feed(8'h00); feed(8'h80); feed(8'hFF); feed(8'hFF);
    run_writes(1, 40, to);
    step();
    tests++; if (to) begin fails++; $display("FAIL sign_timeout: got %0d writes want 1", wr_i.size()); end
    if (wr_i.size() > 0) begin
      tests++; if (wr_i[0] !== 32'hFE000000) begin fails++; $display("FAIL sign_i: got %h want fe000000", wr_i[0]); end
      tests++; if (wr_q[0] !== 32'hFFFFFC00) begin fails++; $display("FAIL sign_q: got %h want fffffc00", wr_q[0]); end
    end
    tests++; if (sample_count !== 32'd2) begin fails++; $display("FAIL sign_count: got %0d want 2", sample_count); end
  endtask

  task automatic test_backpressure();
    bit to;
    int k;
    int src_before;
    int wr_before;
    begin_test();
    want_q_full = 1;
    for (int i = 0; i < 8; i++) feed(8'($urandom));
    k = 0;
    while (nb < 4 && k < 20) begin step(); k++; end
    src_before = src.size();
    wr_before  = wr_i.size();
    for (int i = 0; i < 10; i++) step();
    tests++; if (src.size() !== src_before) begin fails++; $display("FAIL bp_no_pop: got %0d bytes left want %0d", src.size(), src_before); end
    tests++; if (wr_i.size() !== wr_before) begin fails++; $display("FAIL bp_no_write: got %0d writes want %0d", wr_i.size(), wr_before); end
    want_q_full = 0;
    step();
    tests++; if (wr_i.size() !== wr_before + 1) begin fails++; $display("FAIL bp_release_write: got %0d writes want %0d", wr_i.size(), wr_before + 1); end
    step();
    tests++; if (src.size() !== src_before - 1) begin fails++; $display("FAIL bp_resume_pop: got %0d bytes left want %0d", src.size(), src_before - 1); end
    run_writes(1, 40, to);
    step();
    tests++; if (wr_i.size() !== 2) begin fails++; $display("FAIL bp_count: got %0d writes want 2", wr_i.size()); end
    for (int s = 0; s < wr_i.size() && s < 2; s++) begin
      tests++;
      if (wr_i[s] !== ref_q(fed[4*s], fed[4*s+1]) || wr_q[s] !== ref_q(fed[4*s+2], fed[4*s+3])) begin
        fails++;
        $display("FAIL bp_value[%0d]: got %h/%h want %h/%h", s, wr_i[s], wr_q[s],
                 ref_q(fed[4*s], fed[4*s+1]), ref_q(fed[4*s+2], fed[4*s+3]));
      end
    end
    tests++; if (terr !== 0 || viol !== 0) begin fails++; $display("FAIL bp_protocol: got %0d/%0d want 0/0", terr, viol); end
  endtask

  task automatic test_starved();
    bit to;
    begin_test();
    gap = 3;
    feed(8'h34); feed(8'h12); feed(8'h78); feed(8'h56);
    run_writes(1, 100, to);
    gap = 0;
    step();
    tests++; if (to) begin fails++; $display("FAIL starve_timeout: got %0d writes want 1", wr_i.size()); end
    if (wr_i.size() > 0) begin
      tests++; if (wr_i[0] !== 32'h0048D000 || wr_q[0] !== 32'h0159E000) begin
        fails++; $display("FAIL starve_value: got %h/%h want 0048d000/0159e000", wr_i[0], wr_q[0]);
      end
    end
    tests++; if (terr !== 0 || viol !== 0) begin fails++; $display("FAIL starve_protocol: got %0d/%0d want 0/0", terr, viol); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k;
    begin_test();
    feed(8'($urandom)); feed(8'($urandom));
    k = 0;
    while (src.size() != 0 && k < 20) begin step(); k++; end
    src.push_back(8'h01); src.push_back(8'h00); src.push_back(8'h02); src.push_back(8'h00);
    apply_reset();
    tests++; if (i_out !== 32'h0 || q_out !== 32'h0) begin fails++; $display("FAIL rmid_outs: got %h/%h want 0/0", i_out, q_out); end
    tests++; if (sample_count !== 32'h0) begin fails++; $display("FAIL rmid_count: got %0d want 0", sample_count); end
    tests++; if (in_rd_en !== 1'b0) begin fails++; $display("FAIL rmid_rd_en: got %b want 0", in_rd_en); end
    release_reset();
    begin_test();
    fed.push_back(8'h01); fed.push_back(8'h00); fed.push_back(8'h02); fed.push_back(8'h00);
    run_writes(1, 40, to);
    step();
    tests++; if (to) begin fails++; $display("FAIL rmid_timeout: got %0d writes want 1", wr_i.size()); end
    if (wr_i.size() > 0) begin
      tests++; if (wr_i[0] !== 32'h00000400) begin fails++; $display("FAIL rmid_i: got %h want 00000400", wr_i[0]); end
      tests++; if (wr_q[0] !== 32'h00000800) begin fails++; $display("FAIL rmid_q: got %h want 00000800", wr_q[0]); end
    end
    tests++; if (sample_count !== 32'd1) begin fails++; $display("FAIL rmid_count_after: got %0d want 1", sample_count); end
  endtask

  task automatic test_stream();
    bit to;
    int bad_gap;
    int bad_val;
    apply_reset();
    release_reset();
    begin_test();
    for (int i = 0; i < 256; i++) feed(8'($urandom));
    run_writes(64, 600, to);
    step();
    tests++; if (wr_i.size() !== 64) begin fails++; $display("FAIL stream_count: got %0d writes want 64", wr_i.size()); end
    bad_gap = 0;
    bad_val = 0;
    for (int s = 0; s < wr_i.size(); s++) begin
      if (s > 0 && wr_cyc[s] - wr_cyc[s-1] != 5) bad_gap++;
      if (4*s+3 >= fed.size()) bad_val++;
      else if (wr_i[s] !== ref_q(fed[4*s], fed[4*s+1]) || wr_q[s] !== ref_q(fed[4*s+2], fed[4*s+3])) bad_val++;
    end
    tests++; if (bad_gap !== 0) begin fails++; $display("FAIL stream_spacing: got %0d bad gaps want 0", bad_gap); end
    tests++; if (bad_val !== 0) begin fails++; $display("FAIL stream_values: got %0d bad samples want 0", bad_val); end
    tests++; if (sample_count !== 32'd64) begin fails++; $display("FAIL stream_sample_count: got %0d want 64", sample_count); end
    tests++; if (terr !== 0 || viol !== 0) begin fails++; $display("FAIL stream_protocol: got %0d/%0d want 0/0", terr, viol); end
  endtask

  task automatic test_random_stall();
    bit to;
    int bad_val;
    begin_test();
    rand_full  = 1;
    rand_empty = 1;
    for (int i = 0; i < 200; i++) feed(8'($urandom));
    run_writes(50, 3000, to);
    rand_full  = 0;
    rand_empty = 0;
    step();
    tests++; if (wr_i.size() !== 50) begin fails++; $display("FAIL rand_count: got %0d writes want 50", wr_i.size()); end
    bad_val = 0;
    for (int s = 0; s < wr_i.size(); s++) begin
      if (4*s+3 >= fed.size()) bad_val++;
      else if (wr_i[s] !== ref_q(fed[4*s], fed[4*s+1]) || wr_q[s] !== ref_q(fed[4*s+2], fed[4*s+3])) bad_val++;
    end
    tests++; if (bad_val !== 0) begin fails++; $display("FAIL rand_values: got %0d bad samples want 0", bad_val); end
    tests++; if (terr !== 0 || viol !== 0) begin fails++; $display("FAIL rand_protocol: got %0d/%0d want 0/0", terr, viol); end
    tests++; if (sample_count !== 32'(n_since_reset)) begin fails++; $display("FAIL rand_sample_count: got %0d want %0d", sample_count, n_since_reset); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_starved();
    test_reset_mid();
    test_stream();
    test_random_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
